// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, ALU modes, T-states and the control word.
package cpu_pkg;

    localparam int unsigned OPW   = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned IW    = OPW + AW;
    localparam int unsigned MODEW = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_ADC = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_STA = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hD;
    localparam logic [3:0] OP_RSV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [MODEW-1:0] ALU_ADD = 3'b000;
    localparam logic [MODEW-1:0] ALU_ADC = 3'b001;
    localparam logic [MODEW-1:0] ALU_SUB = 3'b010;
    localparam logic [MODEW-1:0] ALU_AND = 3'b101;
    localparam logic [MODEW-1:0] ALU_OR  = 3'b110;
    localparam logic [MODEW-1:0] ALU_XOR = 3'b111;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, HALT} tstate_t;

    typedef struct packed {
        logic             halted;
        logic [MODEW-1:0] alu_mode;
        logic             alu_eo;
        logic             alu_ee;
        logic             out_load;
        logic             b_load;
        logic             a_oe;
        logic             a_load;
        logic             ram_we;
        logic             ram_oe;
        logic             mar_load;
        logic             pc_load;
        logic             pc_inc;
        logic             pc_oe;
        logic             operand_oe;
    } ctrl_word_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic [MODEW-1:0] alu_mode_of(input logic [3:0] op);
        case (op)
            OP_ADC:  return ALU_ADC;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (T-state, opcode, flags) to the control word.
module ctrl_decode
    import cpu_pkg::*;
(
    input  tstate_t    tstate,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (tstate)
            T0: begin
                ctrl.pc_oe    = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            T1: begin
                ctrl.ram_oe = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            T2: begin
                if (opcode == OP_LDA || opcode == OP_STA || is_alu_op(opcode)) begin
                    ctrl.operand_oe = 1'b1;
                    ctrl.mar_load   = 1'b1;
                end else if (opcode == OP_LDI) begin
                    ctrl.operand_oe = 1'b1;
                    ctrl.a_load     = 1'b1;
                end else if (opcode == OP_JMP
                             || (opcode == OP_JC && flag_carry)
                             || (opcode == OP_JZ && flag_zero)) begin
                    ctrl.operand_oe = 1'b1;
                    ctrl.pc_load    = 1'b1;
                end else if (opcode == OP_OUT) begin
                    ctrl.a_oe     = 1'b1;
                    ctrl.out_load = 1'b1;
                end
            end
            T3: begin
                if (opcode == OP_LDA) begin
                    ctrl.ram_oe = 1'b1;
                    ctrl.a_load = 1'b1;
                end else if (opcode == OP_STA) begin
                    ctrl.a_oe   = 1'b1;
                    ctrl.ram_we = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    ctrl.ram_oe = 1'b1;
                    ctrl.b_load = 1'b1;
                end
            end
            // ALU result is registered: compute in T4, drive the bus in T5
            T4: begin
                ctrl.alu_ee   = 1'b1;
                ctrl.alu_mode = alu_mode_of(opcode);
            end
            T5: begin
                ctrl.alu_eo   = 1'b1;
                ctrl.a_load   = 1'b1;
                ctrl.alu_mode = alu_mode_of(opcode);
            end
            HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control unit: holds IR and T-state, registers the decoded control word of the upcoming cycle.
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 4,
    parameter int unsigned AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPW+AW-1:0]  bus_in,
    input  logic               flag_zero,
    input  logic               flag_carry,
    output logic [AW-1:0]      operand,
    output logic               operand_oe,
    output logic               pc_oe,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               mar_load,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               a_load,
    output logic               a_oe,
    output logic               b_load,
    output logic               out_load,
    output logic [2:0]         alu_mode,
    output logic               alu_ee,
    output logic               alu_eo,
    output logic               halted
);

    tstate_t             state, next_state;
    logic [OPW+AW-1:0]   ir, next_ir;
    logic [OPW-1:0]      next_op;
    logic                active;
    ctrl_word_t          ctl, next_ctl;

    assign next_op = next_ir[OPW+AW-1:AW];

    // Next-state/IR; 'active' holds the first cycle after reset in T0 so fetch starts cleanly
    always_comb begin
        next_state = state;
        next_ir    = ir;
        if (!active) begin
            next_state = T0;
        end else begin
            case (state)
                T0: next_state = T1;
                T1: begin
                    next_ir = bus_in;
                    if (next_ir[OPW+AW-1:AW] == OP_NOP || next_ir[OPW+AW-1:AW] == OP_RSV)
                        next_state = T0;
                    else if (next_ir[OPW+AW-1:AW] == OP_HLT)
                        next_state = HALT;
                    else
                        next_state = T2;
                end
                T2: begin
                    if (next_op == OP_LDA || next_op == OP_STA || is_alu_op(next_op))
                        next_state = T3;
                    else
                        next_state = T0;
                end
                T3:      next_state = is_alu_op(next_op) ? T4 : T0;
                T4:      next_state = T5;
                T5:      next_state = T0;
                HALT:    next_state = HALT;
                default: next_state = T0;
            endcase
        end
    end

    ctrl_decode u_decode (
        .tstate     (next_state),
        .opcode     (next_op),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .ctrl       (next_ctl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= T0;
            ir     <= '0;
            active <= 1'b0;
            ctl    <= '0;
        end else begin
            state  <= next_state;
            ir     <= next_ir;
            active <= 1'b1;
            ctl    <= next_ctl;
        end
    end

    assign operand    = ir[AW-1:0];
    assign operand_oe = ctl.operand_oe;
    assign pc_oe      = ctl.pc_oe;
    assign pc_inc     = ctl.pc_inc;
    assign pc_load    = ctl.pc_load;
    assign mar_load   = ctl.mar_load;
    assign ram_oe     = ctl.ram_oe;
    assign ram_we     = ctl.ram_we;
    assign a_load     = ctl.a_load;
    assign a_oe       = ctl.a_oe;
    assign b_load     = ctl.b_load;
    assign out_load   = ctl.out_load;
    assign alu_mode   = ctl.alu_mode;
    assign alu_ee     = ctl.alu_ee;
    assign alu_eo     = ctl.alu_eo;
    assign halted     = ctl.halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed and random instructions against a per-opcode cycle table.
module tb_ctrl_sequencer;

    localparam logic [16:0] S_OPOE = 17'h00001;
    localparam logic [16:0] S_PCOE = 17'h00002;
    localparam logic [16:0] S_PCIN = 17'h00004;
    localparam logic [16:0] S_PCLD = 17'h00008;
    localparam logic [16:0] S_MAR  = 17'h00010;
    localparam logic [16:0] S_RMOE = 17'h00020;
    localparam logic [16:0] S_RMWE = 17'h00040;
    localparam logic [16:0] S_ALD  = 17'h00080;
    localparam logic [16:0] S_AOE  = 17'h00100;
    localparam logic [16:0] S_BLD  = 17'h00200;
    localparam logic [16:0] S_OLD  = 17'h00400;
    localparam logic [16:0] S_EE   = 17'h00800;
    localparam logic [16:0] S_EO   = 17'h01000;
    localparam logic [16:0] S_HLT  = 17'h10000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       flag_zero, flag_carry;
    logic [3:0] operand;
    logic       operand_oe, pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we;
    logic       a_load, a_oe, b_load, out_load, alu_ee, alu_eo, halted;
    logic [2:0] alu_mode;
    logic [16:0] obs;

    int checks = 0;
    int passes = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .operand(operand), .operand_oe(operand_oe),
        .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_oe(ram_oe), .ram_we(ram_we), .a_load(a_load), .a_oe(a_oe),
        .b_load(b_load), .out_load(out_load), .alu_mode(alu_mode),
        .alu_ee(alu_ee), .alu_eo(alu_eo), .halted(halted)
    );

    assign obs = {halted, alu_mode, alu_eo, alu_ee, out_load, b_load, a_oe, a_load,
                  ram_we, ram_oe, mar_load, pc_load, pc_inc, pc_oe, operand_oe};

    task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    function automatic logic [16:0] mode_bits(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            4'h3: m = 3'b001;
            4'h4: m = 3'b010;
            4'h5: m = 3'b101;
            4'h6: m = 3'b110;
            4'h7: m = 3'b111;
            default: m = 3'b000;
        endcase
        return 17'(m) << 13;
    endfunction

    // Expected per-cycle strobes for one instruction, straight from the opcode table
    function automatic void model(input logic [7:0] ins, input logic fz, input logic fc);
        logic [3:0] op;
        op = ins[7:4];
        exp_q.delete();
        exp_q.push_back(S_PCOE | S_MAR);
        exp_q.push_back(S_RMOE | S_PCIN);
        case (op)
            4'h1: begin exp_q.push_back(S_OPOE | S_MAR); exp_q.push_back(S_RMOE | S_ALD); end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                exp_q.push_back(S_OPOE | S_MAR);
                exp_q.push_back(S_RMOE | S_BLD);
                exp_q.push_back(S_EE | mode_bits(op));
                exp_q.push_back(S_EO | S_ALD | mode_bits(op));
            end
            4'h8: begin exp_q.push_back(S_OPOE | S_MAR); exp_q.push_back(S_AOE | S_RMWE); end
            4'h9: exp_q.push_back(S_OPOE | S_ALD);
            4'hA: exp_q.push_back(S_OPOE | S_PCLD);
            4'hB: exp_q.push_back(fc ? (S_OPOE | S_PCLD) : 17'h0);
            4'hC: exp_q.push_back(fz ? (S_OPOE | S_PCLD) : 17'h0);
            4'hD: exp_q.push_back(S_AOE | S_OLD);
            4'hF: for (int k = 0; k < 20; k++) exp_q.push_back(S_HLT);
            default: ;
        endcase
    endfunction

    // Enters on the cycle before T0; abort_at>=0 pulses reset inside that cycle
    task automatic run_instr(input logic [7:0] ins, input logic fz, input logic fc, input int abort_at);
        int drv;
        model(ins, fz, fc);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            check($sformatf("ctrl_ins%02h_c%0d", ins, i), obs, exp_q[i]);
            if (exp_q[i][0]) check($sformatf("operand_ins%02h", ins), 17'(operand), 17'(ins[3:0]));
            drv = int'(pc_oe) + int'(ram_oe) + int'(a_oe) + int'(alu_eo) + int'(operand_oe);
            check($sformatf("bus_drivers_ins%02h_c%0d", ins, i), 17'(drv <= 1), 17'h1);
            check($sformatf("inc_and_load_ins%02h_c%0d", ins, i), 17'(pc_inc & pc_load), 17'h0);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check("abort_reset_ctrl", obs, 17'h0);
                check("abort_reset_operand", 17'(operand), 17'h0);
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            bus_in = (i == 1) ? ins : 8'($urandom);
            if (i == 0) begin
                flag_zero  = fz;
                flag_carry = fc;
            end else if (i >= 2) begin
                flag_zero  = 1'($urandom);
                flag_carry = 1'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] ins;
        rst_n = 1'b0; bus_in = 8'h00; flag_zero = 1'b0; flag_carry = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_ctrl", obs, 17'h0);
        end
        check("reset_operand", 17'(operand), 17'h0);
        @(negedge clk) rst_n = 1'b1;

        run_instr(8'h2E, 1'b0, 1'b0, -1);
        run_instr(8'h43, 1'b1, 1'b0, -1);
        run_instr(8'h75, 1'b0, 1'b1, -1);
        run_instr(8'hB7, 1'b1, 1'b0, -1);
        run_instr(8'hB7, 1'b0, 1'b1, -1);
        run_instr(8'hC3, 1'b0, 1'b1, -1);
        run_instr(8'hC3, 1'b1, 1'b0, -1);
        run_instr(8'h15, 1'b0, 1'b0, -1);
        run_instr(8'h8A, 1'b0, 1'b0, -1);
        run_instr(8'h9C, 1'b0, 1'b0, -1);
        run_instr(8'hA1, 1'b0, 1'b0, -1);
        run_instr(8'hD0, 1'b0, 1'b0, -1);
        run_instr(8'h07, 1'b0, 1'b0, -1);
        run_instr(8'hE9, 1'b1, 1'b1, -1);
        run_instr(8'h5F, 1'b0, 1'b0, -1);
        run_instr(8'h63, 1'b0, 1'b0, -1);
        run_instr(8'h3B, 1'b0, 1'b0, -1);

        // ADD aborted by reset in T3, then fetch resumes
        run_instr(8'h2E, 1'b0, 1'b0, 3);
        run_instr(8'h96, 1'b0, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            run_instr(ins, 1'($urandom), 1'($urandom), -1);
        end

        run_instr(8'hF0, 1'b1, 1'b1, -1);
        rst_n = 1'b0;
        #1 check("halt_reset_ctrl", obs, 17'h0);
        @(negedge clk) rst_n = 1'b1;
        run_instr(8'h95, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
